// File: rtl/program_loader_pkg.sv
//------------------------------------------------------------------------------
// program_loader_pkg : shared loader state encoding and link constants
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package program_loader_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_HELLO      = 4'd1,
    ST_HELLO_WAIT = 4'd2,
    ST_LEN        = 4'd3,
    ST_DATA       = 4'd4,
    ST_ACK        = 4'd5,
    ST_ACK_WAIT   = 4'd6,
    ST_DONE       = 4'd7,
    ST_ERROR      = 4'd8
  } loader_state_t;

  localparam logic [7:0] c_SYNC_BYTE = 8'hAA;
  localparam logic       c_MODE_LOAD = 1'b1;

endpackage

`default_nettype wire

// File: rtl/program_loader_byte_packer.sv
//------------------------------------------------------------------------------
// program_loader_byte_packer : MSB-first byte to 32-bit word assembler
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module program_loader_byte_packer (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_clr,
  input  logic        i_valid,
  input  logic [7:0]  i_byte,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  logic [31:0] r_shift;
  logic [1:0]  r_cnt;
  logic        r_word_valid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_shift      <= 32'd0;
      r_cnt        <= 2'd0;
      r_word_valid <= 1'b0;
    end else if (i_clr) begin
      r_shift      <= 32'd0;
      r_cnt        <= 2'd0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= 1'b0;
      if (i_valid) begin
        r_shift <= {r_shift[23:0], i_byte};
        r_cnt   <= r_cnt + 2'd1;
        if (r_cnt == 2'd3) begin
          r_word_valid <= 1'b1;
        end
      end
    end
  end

  assign o_word_valid = r_word_valid;
  assign o_word       = r_shift;

endmodule

`default_nettype wire

// File: rtl/program_loader.sv
//------------------------------------------------------------------------------
// program_loader : UART boot loader writing a host-supplied program into imem
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module program_loader
  import program_loader_pkg::*;
#(
  parameter int         ADDR_W    = 14,
  parameter logic [7:0] SYNC_BYTE = c_SYNC_BYTE
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_ferr,
  input  logic              tx_busy,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_din,
  output logic              imem_we,
  output logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [32:0] c_CAPACITY = 33'd1 << ADDR_W;

  loader_state_t     r_state;
  logic [7:0]        r_tx_data;
  logic              r_tx_start;
  logic [ADDR_W:0]   r_word_count;
  logic [ADDR_W:0]   r_n;
  logic              r_first;
  logic              r_busy;
  logic              r_done;
  logic              r_error;

  logic              w_collect;
  logic              w_pack_valid;
  logic              w_bad_byte;
  logic              w_word_valid;
  logic [31:0]       w_word;
  logic [ADDR_W:0]   w_count_nx;

  assign w_collect    = (r_state == ST_LEN) || (r_state == ST_DATA);
  assign w_pack_valid = w_collect && rx_valid && !rx_ferr;
  assign w_bad_byte   = w_collect && rx_valid && rx_ferr;
  assign w_count_nx   = r_word_count + 1'b1;

  // Packer is held clear outside LEN/DATA so every collecting state starts at byte 0.
  program_loader_byte_packer u_packer (
    .clk          (clk),
    .rstn         (rstn),
    .i_clr        (!w_collect),
    .i_valid      (w_pack_valid),
    .i_byte       (rx_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= ST_IDLE;
      r_tx_data    <= 8'd0;
      r_tx_start   <= 1'b0;
      r_word_count <= '0;
      r_n          <= '0;
      r_first      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            r_state      <= ST_HELLO;
            r_tx_start   <= 1'b1;
            r_tx_data    <= SYNC_BYTE;
            r_word_count <= '0;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
          end
        end
        ST_HELLO, ST_ACK: begin
          r_state <= (r_state == ST_HELLO) ? ST_HELLO_WAIT : ST_ACK_WAIT;
          r_first <= 1'b1;
        end
        // uart_tx raises busy one cycle after tx_start, so the first cycle is blind.
        ST_HELLO_WAIT, ST_ACK_WAIT: begin
          if (r_first) begin
            r_first <= 1'b0;
          end else if (!tx_busy) begin
            if (r_state == ST_HELLO_WAIT) begin
              r_state <= ST_LEN;
            end else begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        ST_LEN: begin
          if (w_bad_byte || (w_word_valid && ({1'b0, w_word} > c_CAPACITY))) begin
            r_state <= ST_ERROR;
            r_busy  <= 1'b0;
            r_error <= 1'b1;
          end else if (w_word_valid) begin
            r_n <= w_word[ADDR_W:0];
            if (w_word == 32'd0) begin
              r_state    <= ST_ACK;
              r_tx_start <= 1'b1;
              r_tx_data  <= SYNC_BYTE;
            end else begin
              r_state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (w_word_valid) begin
            r_word_count <= w_count_nx;
            if (w_count_nx == r_n) begin
              r_state    <= ST_ACK;
              r_tx_start <= 1'b1;
              r_tx_data  <= SYNC_BYTE;
            end
          end
          if (w_bad_byte) begin
            r_state    <= ST_ERROR;
            r_tx_start <= 1'b0;
            r_busy     <= 1'b0;
            r_error    <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign tx_data    = r_tx_data;
  assign tx_start   = r_tx_start;
  assign imem_we    = w_word_valid && (r_state == ST_DATA);
  assign imem_addr  = r_word_count[ADDR_W-1:0];
  assign imem_din   = w_word;
  assign word_count = r_word_count;
  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;

endmodule

`default_nettype wire
